// File: rtl/slr_credit_sink.sv
// slr_credit_sink: receive endpoint of a credit-flow-controlled SLR crossing.
// Incoming words land in a FIFO built from a storage array plus a
// first-word-fall-through output register. A one-cycle credit pulse is returned
// upstream for every word the consumer pops.
// Optional build macro SLR_CREDIT_SINK_OVF_CHECK_EN: when defined, pushes into a
// full FIFO are dropped, a sticky overflow flag is raised and a simulation
// assertion reports the violation. When undefined, overflow is tied low.
module slr_credit_sink #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned LEVEL_W = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               sreset,
  input  logic               in_valid,
  input  logic [WIDTH-1:0]   in_data,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  input  logic               out_ready,
  output logic               credit_out,
  output logic [LEVEL_W-1:0] level,
  output logic               overflow
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0]   mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   out_data_q, out_data_d;
  logic               credit_q;

  logic pop;
  logic push;
  logic mem_empty;
  logic head_free;
  logic bypass;
  logic mem_wr;

`ifdef SLR_CREDIT_SINK_OVF_CHECK_EN
  logic illegal_push;
  logic overflow_q;
`endif

  // Push/pop qualification and FWFT head-register steering.
  // The array holds level minus the head register; when it is empty and the
  // head is free, an incoming word bypasses the array straight into the head.
  always_comb begin
    pop = out_valid_q && out_ready;
`ifdef SLR_CREDIT_SINK_OVF_CHECK_EN
    push         = in_valid && ((level_q != LEVEL_W'(DEPTH)) || pop);
    illegal_push = in_valid && !push;
`else
    push = in_valid;
`endif
    mem_empty = (level_q == LEVEL_W'(out_valid_q));
    head_free = !out_valid_q || pop;
    bypass    = push && mem_empty && head_free;
    mem_wr    = push && !bypass;

    rd_ptr_d    = rd_ptr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (head_free) begin
      if (!mem_empty) begin
        out_data_d  = mem_q[rd_ptr_q];
        out_valid_d = 1'b1;
        rd_ptr_d    = rd_ptr_q + PTR_W'(1);
      end else if (push) begin
        out_data_d  = in_data;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end

    wr_ptr_d = mem_wr ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
    level_d  = level_q + LEVEL_W'(push) - LEVEL_W'(pop);
  end

  // Storage array write port; contents need no reset.
  always_ff @(posedge clk) begin
    if (mem_wr) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

  // Control state, head register and credit pulse.
  always_ff @(posedge clk) begin
    if (sreset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      out_valid_q <= 1'b0;
      credit_q    <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      out_valid_q <= out_valid_d;
      credit_q    <= pop;
    end
  end

  // Head data register; value is don't-care while out_valid is low.
  always_ff @(posedge clk) begin
    out_data_q <= out_data_d;
  end

`ifdef SLR_CREDIT_SINK_OVF_CHECK_EN
  // Sticky credit-violation flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (sreset) begin
      overflow_q <= 1'b0;
    end else if (illegal_push) begin
      overflow_q <= 1'b1;
    end
  end

  assign overflow = overflow_q;

  a_no_illegal_push: assert property (@(posedge clk) disable iff (sreset) !illegal_push)
    else $warning("slr_credit_sink: push into full FIFO dropped");
`else
  assign overflow = 1'b0;
`endif

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign credit_out = credit_q;
  assign level      = level_q;

endmodule

// File: tb/tb_slr_credit_sink.sv
// Testbench for slr_credit_sink (WIDTH=16, DEPTH=16).
// Honors SLR_CREDIT_SINK_OVF_CHECK_EN to select overflow expectations.
module tb_slr_credit_sink;

  localparam int unsigned WIDTH   = 16;
  localparam int unsigned DEPTH   = 16;
  localparam int unsigned LEVEL_W = $clog2(DEPTH + 1);

  logic               clk;
  logic               sreset;
  logic               in_valid;
  logic [WIDTH-1:0]   in_data;
  logic               out_valid;
  logic [WIDTH-1:0]   out_data;
  logic               out_ready;
  logic               credit_out;
  logic [LEVEL_W-1:0] level;
  logic               overflow;

  int unsigned errors;
  int unsigned checks;

  logic [WIDTH-1:0] exp_q [$];
  logic             mon_en;
  int unsigned      cred_cnt;
  int unsigned      pop_cnt;
  int unsigned      max_lvl;

  typedef struct {
    logic             rst;
    logic             iv;
    logic [WIDTH-1:0] din;
    logic             rdy;
    logic             ev;
    logic [WIDTH-1:0] ed;
    int unsigned      elvl;
    logic             ecr;
  } vec_t;

  vec_t vecs[12];

  slr_credit_sink #(
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH),
    .LEVEL_W(LEVEL_W)
  ) dut (
    .clk       (clk),
    .sreset    (sreset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .credit_out(credit_out),
    .level     (level),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int unsigned act, input int unsigned exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: pops are observed mid-cycle, where out_valid/out_ready
  // hold the values the next rising edge will sample.
  always @(negedge clk) begin
    if (!sreset && credit_out) cred_cnt++;
    if (32'(level) > max_lvl) max_lvl = 32'(level);
    if (mon_en && !sreset && out_valid && out_ready) begin
      pop_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got %0h expected none", out_data);
      end else begin
        logic [WIDTH-1:0] e;
        e = exp_q.pop_front();
        if (out_data !== e) begin
          errors++;
          $display("FAIL sb_data: got %0h expected %0h", out_data, e);
        end
      end
    end
  end

  // Drive a word and record it as expected output.
  task automatic drive_push(input logic [WIDTH-1:0] d);
    in_valid = 1'b1;
    in_data  = d;
    exp_q.push_back(d);
  endtask

  task automatic do_reset();
    sreset   = 1'b1;
    in_valid = 1'b0;
    tick();
    sreset   = 1'b0;
    exp_q.delete();
  endtask

  // Drain with out_ready high until empty, bounded.
  task automatic drain(input string nm);
    int unsigned n;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while (level != 0 && n < 5000) begin
      tick();
      n++;
    end
    chk({nm, "_timeout"}, (n < 5000) ? 1 : 0, 1);
    tick();
  endtask

  initial begin
    errors    = 0;
    checks    = 0;
    mon_en    = 1'b0;
    cred_cnt  = 0;
    pop_cnt   = 0;
    max_lvl   = 0;
    sreset    = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;

    //          rst iv  din       rdy  ev  ed       lvl cr
    vecs[0]  = '{1, 0, 16'h0000, 0,   0, 16'h0000, 0, 0};
    vecs[1]  = '{1, 1, 16'h1234, 0,   0, 16'h0000, 0, 0};
    vecs[2]  = '{0, 1, 16'hA5A5, 1,   1, 16'hA5A5, 1, 0};
    vecs[3]  = '{0, 0, 16'h0000, 1,   0, 16'h0000, 0, 1};
    vecs[4]  = '{0, 0, 16'h0000, 1,   0, 16'h0000, 0, 0};
    vecs[5]  = '{0, 1, 16'h0001, 0,   1, 16'h0001, 1, 0};
    vecs[6]  = '{0, 1, 16'h0002, 1,   1, 16'h0002, 1, 1};
    vecs[7]  = '{0, 1, 16'h0003, 0,   1, 16'h0002, 2, 0};
    vecs[8]  = '{0, 0, 16'h0000, 0,   1, 16'h0002, 2, 0};
    vecs[9]  = '{0, 0, 16'h0000, 1,   1, 16'h0003, 1, 1};
    vecs[10] = '{0, 0, 16'h0000, 1,   0, 16'h0000, 0, 1};
    vecs[11] = '{0, 0, 16'h0000, 1,   0, 16'h0000, 0, 0};

    // Table: reset, single word, bypass at level 1, hold, empty pop
    for (int i = 0; i < 12; i++) begin
      sreset    = vecs[i].rst;
      in_valid  = vecs[i].iv;
      in_data   = vecs[i].din;
      out_ready = vecs[i].rdy;
      tick();
      chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(vecs[i].ev));
      chk($sformatf("vec%0d_level", i), 32'(level), vecs[i].elvl);
      chk($sformatf("vec%0d_credit", i), 32'(credit_out), 32'(vecs[i].ecr));
      chk($sformatf("vec%0d_ovf", i), 32'(overflow), 0);
      if (vecs[i].ev)
        chk($sformatf("vec%0d_data", i), 32'(out_data), 32'(vecs[i].ed));
    end

    // Fill to full, then simultaneous push/pop at full, then drain in order
    mon_en = 1'b1;
    do_reset();
    out_ready = 1'b0;
    cred_cnt  = 0;
    pop_cnt   = 0;
    for (int i = 0; i < 16; i++) begin
      drive_push(16'(i));
      tick();
    end
    in_valid = 1'b0;
    tick();
    chk("full_level", 32'(level), 16);
    chk("full_credits", cred_cnt, 0);
    chk("full_ovf", 32'(overflow), 0);
    chk("full_head", 32'(out_data), 0);

    drive_push(16'h0010);
    out_ready = 1'b1;
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("pushpop_full_level", 32'(level), 16);
    chk("pushpop_full_ovf", 32'(overflow), 0);
    chk("pushpop_full_credit", 32'(credit_out), 1);
    tick();

`ifdef SLR_CREDIT_SINK_OVF_CHECK_EN
    in_valid = 1'b1;
    in_data  = 16'hDEAD;
    tick();
    in_valid = 1'b0;
    chk("ovf_set", 32'(overflow), 1);
    chk("ovf_level", 32'(level), 16);
`endif

    drain("fill_drain");
    chk("fill_pops", pop_cnt, 17);
    chk("fill_credits", cred_cnt, 17);
    chk("fill_sb_empty", exp_q.size(), 0);
`ifdef SLR_CREDIT_SINK_OVF_CHECK_EN
    chk("ovf_sticky", 32'(overflow), 1);
    do_reset();
    chk("ovf_cleared", 32'(overflow), 0);
`else
    chk("ovf_tied_low", 32'(overflow), 0);
`endif

    // Streaming: credit-respecting sender, 50% random out_ready
    begin
      int unsigned credits;
      int unsigned sent;
      int unsigned n;
      do_reset();
      cred_cnt = 0;
      pop_cnt  = 0;
      max_lvl  = 0;
      credits  = DEPTH;
      sent     = 0;
      n        = 0;
      while (sent < 1000 && n < 20000) begin
        if (credit_out) credits++;
        out_ready = 1'($urandom_range(0, 1));
        if (credits > 0 && $urandom_range(0, 3) != 0) begin
          drive_push(16'($urandom));
          credits--;
          sent++;
        end else begin
          in_valid = 1'b0;
        end
        tick();
        n++;
      end
      chk("stream_timeout", (n < 20000) ? 1 : 0, 1);
      drain("stream_drain");
      chk("stream_pops", pop_cnt, 1000);
      chk("stream_credits", cred_cnt, 1000);
      chk("stream_sb_empty", exp_q.size(), 0);
      chk("stream_max_level_ok", (max_lvl <= 16) ? 1 : 0, 1);
    end

    // Mid-stream reset at level 7: flush without credits, then fresh word first
    out_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      drive_push(16'(16'h0100 + i));
      tick();
    end
    in_valid = 1'b0;
    tick();
    chk("mid_level7", 32'(level), 7);
    sreset = 1'b1;
    tick();
    sreset = 1'b0;
    exp_q.delete();
    chk("mid_rst_valid", 32'(out_valid), 0);
    chk("mid_rst_level", 32'(level), 0);
    chk("mid_rst_credit", 32'(credit_out), 0);
    cred_cnt  = 0;
    pop_cnt   = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    chk("mid_no_credits", cred_cnt, 0);
    drive_push(16'hBEEF);
    tick();
    in_valid = 1'b0;
    chk("mid_new_head", 32'(out_data), 32'h0000BEEF);
    drain("mid_drain");
    chk("mid_pops", pop_cnt, 1);
    chk("mid_credits", cred_cnt, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/slr_credit_sink.md
# slr_credit_sink

Receive-side endpoint for a pipelined multi-SLR data crossing. Forward flops along the crossing carry no backpressure, so this block supplies it. Every word arriving from the far end of the crossing lands in a local FIFO sized to the round-trip latency. A one-cycle credit pulse is returned upstream, through a reverse crossing, each time the consumer drains a word. Sits in the destination SLR and presents a valid/ready stream to local logic.

## Interface
- `WIDTH`, 16, data width in bits.
- `DEPTH`, 16, FIFO entries; power of 2, ≥ 2.
  - Must be ≥ forward crossing latency + reverse credit latency + 2.
  - Upstream sender's credit counter resets to `DEPTH`.
- `LEVEL_W`, `$clog2(DEPTH+1)`, width of fill level output.

- `clk` in 1: single clock for all logic.
- `sreset` in 1: synchronous, active-high reset.
- `in_valid` in 1: word present from crossing; no ready, always accepted.
- `in_data` in `WIDTH`: payload, qualified by `in_valid`.
- `out_valid` out 1: head word available.
- `out_data` out `WIDTH`: head word; stable while `out_valid && !out_ready`.
- `out_ready` in 1: consumer accepts head word when high with `out_valid`.
- `credit_out` out 1: one-cycle pulse per word popped; feeds the reverse crossing.
- `level` out `LEVEL_W`: entries held, including output register.
- `overflow` out 1: sticky credit-violation flag (see Configuration).

## Operation
- Storage is `DEPTH` entries total, organised as an RAM/register array plus a first-word-fall-through output register. The output register counts toward `DEPTH`.
- Push occurs when `in_valid` is high.
  - The push is legal when `level < DEPTH`, or when a pop happens in the same cycle.
- Pop occurs when `out_valid && out_ready`.
- Word order is strictly preserved. No word is duplicated or dropped under legal traffic.
- `level` arithmetic:
  - `level_next = level + push_accepted - pop`.
  - The result never exceeds `DEPTH` and never goes below 0.
  - Pointers are `$clog2(DEPTH)` bits wide and wrap modulo `DEPTH`.
- Push while full with no pop is illegal: the upstream sender has broken the credit protocol. Behaviour depends on the macro.
- Pop with `out_valid` low has no effect and produces no credit.
- Simultaneous push and pop:
  - Level is unchanged.
  - With level = 1, the incoming word moves directly into the output register in the same cycle that the old head leaves.
- Reset (`sreset` high on a `clk` edge), including mid-stream:
  - Empties the FIFO.
  - `out_valid`=0, `credit_out`=0, `level`=0, `overflow`=0.
  - `out_data` is don't-care.
  - No credits are returned for flushed words. The upstream sender must be reset by the same `sreset`.
  - `in_valid` during reset is ignored.

## Timing
- Push-to-output latency is 1 cycle: `in_valid` at edge N gives `out_valid` at edge N+1 when the FIFO was empty.
- Credit latency is 1 cycle: a pop at edge N gives `credit_out` high for exactly the cycle after edge N.
  - Back-to-back pops give a continuous `credit_out` high, one pulse per cycle.
- `level` is registered and updates on the edge after the push/pop.
- `out_valid`, `out_data`, `credit_out`, `level` and `overflow` are all driven directly from flops. There is no combinational path from `in_*` or `out_ready` to any output.
- Sustained throughput is 1 word/cycle with `out_ready` held high.

## Configuration
- `SLR_CREDIT_SINK_OVF_CHECK_EN` defined:
  - An illegal push is dropped and does not corrupt FIFO contents or `level`.
  - `overflow` sets on the following edge and stays set until `sreset`.
  - A simulation assertion fires on the illegal push.
- Macro undefined:
  - `overflow` is tied to 0.
  - No check logic is built.
  - An illegal push is undefined behaviour: it may overwrite the oldest entry.

## Test plan
- Reset then single word: `sreset` 2 cycles, then `in_valid`=1 with `in_data`=0xA5A5 for 1 cycle and `out_ready`=1.
  - Expect `out_valid`=1 and `out_data`=0xA5A5 one cycle later.
  - Expect a `credit_out` pulse the cycle after the pop.
  - Expect `level` to go 0→1→0.
- Fill to full: `DEPTH`=16, push 0..15 with `out_ready`=0.
  - Expect `level`=16, no `credit_out` pulses, `overflow`=0.
  - Then raise `out_ready`: expect data 0..15 in order and 16 consecutive `credit_out` pulses.
- Simultaneous push/pop at full: with `level`=16, assert `in_valid` and `out_ready` in the same cycle.
  - Expect `level` to stay 16, the push to be accepted and `overflow`=0.
- Streaming with random `out_ready` (50%) over 1000 words:
  - Expect the output sequence to equal the input sequence.
  - Expect total `credit_out` pulses = 1000 after drain.
  - Expect `level` never to exceed 16.
- Overflow (macro defined): at `level`=16, push 0xDEAD with `out_ready`=0.
  - Expect `overflow`=1 next cycle.
  - Expect draining to return the original 16 words, no 0xDEAD.
  - Expect `overflow` to stay set until `sreset`.
- Mid-stream reset: with `level`=7, assert `sreset` for 1 cycle.
  - Expect `out_valid`=0 and `level`=0 the next cycle.
  - Expect no `credit_out` pulses for the flushed words.
  - Expect a new word pushed after reset to emerge first.
